// File: rtl/sdram_mem_loader_pkg.sv
// rtl/sdram_mem_loader_pkg.sv - shared types, default widths and helpers for the SDRAM memory loader
package sdram_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int DEF_DATA_W   = 128;
    localparam int DEF_SDRAM_AW = 22;
    localparam int DEF_MEM_AW   = 9;
    localparam int DEF_NUM_CH   = 4;

    // A single-channel build still needs a 1-bit channel select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_mem_loader_if.sv
// rtl/sdram_mem_loader_if.sv - command, SDRAM read and memory write signals (chksum under SDRAM_MEM_LOADER_CHKSUM_EN)
interface sdram_mem_loader_if #(
    parameter int DATA_W   = sdram_mem_loader_pkg::DEF_DATA_W,
    parameter int SDRAM_AW = sdram_mem_loader_pkg::DEF_SDRAM_AW,
    parameter int MEM_AW   = sdram_mem_loader_pkg::DEF_MEM_AW,
    parameter int NUM_CH   = sdram_mem_loader_pkg::DEF_NUM_CH
);
    localparam int CH_W = sdram_mem_loader_pkg::ch_width(NUM_CH);

    logic                start;
    logic [SDRAM_AW-1:0] cmd_src;
    logic [MEM_AW-1:0]   cmd_dst;
    logic [MEM_AW:0]     cmd_len;
    logic [CH_W-1:0]     cmd_ch;
    logic                ready;
    logic                done;
    logic                err;

    logic                sdram_wait;
    logic                sdram_rd;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic                sdram_ack;
    logic [DATA_W-1:0]   sdram_rdata;

    logic [NUM_CH-1:0]   mem_wr;
    logic [MEM_AW-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
`ifdef SDRAM_MEM_LOADER_CHKSUM_EN
    logic [DATA_W-1:0]   chksum;
`endif

    modport master (
        input  start, cmd_src, cmd_dst, cmd_len, cmd_ch,
        input  sdram_wait, sdram_ack, sdram_rdata,
        output ready, done, err,
        output sdram_rd, sdram_addr,
        output mem_wr, mem_addr, mem_data
`ifdef SDRAM_MEM_LOADER_CHKSUM_EN
        , output chksum
`endif
    );

    modport slave (
        output start, cmd_src, cmd_dst, cmd_len, cmd_ch,
        output sdram_wait, sdram_ack, sdram_rdata,
        input  ready, done, err,
        input  sdram_rd, sdram_addr,
        input  mem_wr, mem_addr, mem_data
`ifdef SDRAM_MEM_LOADER_CHKSUM_EN
        , input chksum
`endif
    );

endinterface

// File: rtl/loader_xsum.sv
// rtl/loader_xsum.sv - XOR accumulator over written words, used only under SDRAM_MEM_LOADER_CHKSUM_EN
module loader_xsum #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum ^ din;
        end
    end

endmodule

// File: rtl/sdram_mem_loader.sv
// rtl/sdram_mem_loader.sv - command-driven SDRAM to on-chip memory copy engine (option: SDRAM_MEM_LOADER_CHKSUM_EN)
module sdram_mem_loader
    import sdram_mem_loader_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SDRAM_AW = DEF_SDRAM_AW,
    parameter int MEM_AW   = DEF_MEM_AW,
    parameter int NUM_CH   = DEF_NUM_CH
) (
    input logic                clk,
    input logic                reset,
    sdram_mem_loader_if.master bus
);
    localparam int              CH_W    = ch_width(NUM_CH);
    localparam logic [MEM_AW:0] LEN_ONE = (MEM_AW + 1)'(1);

    state_t              state;
    state_t              state_nx;
    logic [SDRAM_AW-1:0] src_q;
    logic [MEM_AW-1:0]   dst_q;
    logic [MEM_AW:0]     rem_q;
    logic [CH_W-1:0]     ch_q;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;
    logic                ch_bad;
    logic                accept;

    // Widened compare stays meaningful when NUM_CH is not a power of two.
    assign ch_bad = (32'(bus.cmd_ch) >= NUM_CH);
    assign accept = (state == ST_IDLE) && bus.start && !ch_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bus.ready    = 1'b0;
        bus.done     = 1'b0;
        bus.sdram_rd = 1'b0;
        bus.mem_wr   = '0;
        case (state)
            ST_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start && !ch_bad) begin
                    state_nx = (bus.cmd_len == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (!bus.sdram_wait) begin
                    state_nx = ST_READ;
                end
            end
            ST_READ: begin
                bus.sdram_rd = 1'b1;
                if (bus.sdram_ack) begin
                    state_nx = ST_WRITE;
                end
            end
            ST_WRITE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    bus.mem_wr[i] = (ch_q == CH_W'(i));
                end
                state_nx = (rem_q == LEN_ONE) ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            ch_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= (state == ST_IDLE) && bus.start && ch_bad;
            if (accept) begin
                src_q <= bus.cmd_src;
                dst_q <= bus.cmd_dst;
                rem_q <= bus.cmd_len;
                ch_q  <= bus.cmd_ch;
            end
            if ((state == ST_READ) && bus.sdram_ack) begin
                data_q <= bus.sdram_rdata;
            end
            // Addresses wrap naturally at their register widths.
            if (state == ST_WRITE) begin
                src_q <= src_q + SDRAM_AW'(1);
                dst_q <= dst_q + MEM_AW'(1);
                rem_q <= rem_q - LEN_ONE;
            end
        end
    end

    assign bus.err        = err_q;
    assign bus.sdram_addr = src_q;
    assign bus.mem_addr   = dst_q;
    assign bus.mem_data   = data_q;

`ifdef SDRAM_MEM_LOADER_CHKSUM_EN
    loader_xsum #(
        .W(DATA_W)
    ) u_xsum (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (state == ST_WRITE),
        .din   (data_q),
        .sum   (bus.chksum)
    );
`endif

endmodule
